// File: rtl/trellis_bank_sched.sv
// Survivor-memory sequencer: A-D bank rotation, traceback controls, display ping-pong.
// Bank/display outputs 1 cycle after state, TBU controls 3 after a bank change, disp_out_sel 5; no backpressure.
module trellis_bank_sched #(
    parameter int ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    output logic [3:0]            bank_wr_o,
    output logic [4*ADDR_W-1:0]   bank_addr_o,
    output logic                  tbu0_en_o,
    output logic                  tbu1_en_o,
    output logic                  tbu0_sel_o,
    output logic                  tbu1_sel_o,
    output logic [1:0]            tbu0_src0_o,
    output logic [1:0]            tbu0_src1_o,
    output logic [1:0]            tbu1_src0_o,
    output logic [1:0]            tbu1_src1_o,
    output logic [ADDR_W-1:0]     disp_addr0_o,
    output logic [ADDR_W-1:0]     disp_addr1_o,
    output logic                  disp_out_sel_o
);

    localparam logic [ADDR_W-1:0] ONES     = '1;
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] DWR_INIT = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] DRD_INIT = ONES - ADDR_W'(2);

    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]   dwr_cnt_q, dwr_cnt_d, drd_cnt_q, drd_cnt_d;
    logic [1:0]          bank_q, bank_d, bank_q1, bank_q2;
    logic                bank_q3, bank_q4, bank_q5;
    logic [3:0]          bank_wr_q, bank_wr_d;
    logic [4*ADDR_W-1:0] bank_addr_q, bank_addr_d;
    logic [1:0]          rel;
    logic                tbu0_en_q, tbu1_en_q, tbu0_sel_q, tbu0_sel_d, tbu1_sel_q, tbu1_sel_d;
    logic [1:0]          t0s0_q, t0s0_d, t0s1_q, t0s1_d, t1s0_q, t1s0_d, t1s1_q, t1s1_d;
    logic [ADDR_W-1:0]   disp0_q, disp0_d, disp1_q, disp1_d;

    always_comb begin
        wr_cnt_d  = enable_i ? wr_cnt_q + ONE  : '0;
        rd_cnt_d  = enable_i ? rd_cnt_q - ONE  : ONES;
        dwr_cnt_d = enable_i ? dwr_cnt_q - ONE : DWR_INIT;
        drd_cnt_d = enable_i ? drd_cnt_q + ONE : DRD_INIT;
        bank_d    = (enable_i && wr_cnt_q == ONES) ? bank_q + 2'd1 : bank_q;
    end

    // Role of bank k is its distance ahead of the write bank: 0 write, 2 clear, 1/3 read.
    always_comb begin
        bank_wr_d   = '0;
        bank_addr_d = '0;
        rel         = '0;
        for (int k = 0; k < 4; k++) begin
            rel = 2'(k) - bank_q;
            case (rel)
                2'd0: begin
                    bank_wr_d[k]                    = enable_i;
                    bank_addr_d[k*ADDR_W +: ADDR_W] = wr_cnt_q;
                end
                2'd2:    bank_addr_d[k*ADDR_W +: ADDR_W] = '0;
                default: bank_addr_d[k*ADDR_W +: ADDR_W] = rd_cnt_q;
            endcase
        end
    end

    always_comb begin
        t0s0_d = 2'd3; t0s1_d = 2'd2; tbu0_sel_d = 1'b0;
        t1s0_d = 2'd2; t1s1_d = 2'd1; tbu1_sel_d = 1'b1;
        case (bank_q2)
            2'd1: begin
                tbu0_sel_d = 1'b1;
                t1s0_d = 2'd0; t1s1_d = 2'd3; tbu1_sel_d = 1'b0;
            end
            2'd2: begin
                t0s0_d = 2'd1; t0s1_d = 2'd0;
                t1s0_d = 2'd0; t1s1_d = 2'd3;
            end
            2'd3: begin
                t0s0_d = 2'd1; t0s1_d = 2'd0; tbu0_sel_d = 1'b1;
                tbu1_sel_d = 1'b0;
            end
            default: ;
        endcase
        disp0_d = bank_q3 ? dwr_cnt_q : drd_cnt_q;
        disp1_d = bank_q3 ? drd_cnt_q : dwr_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= ONES;
            dwr_cnt_q   <= DWR_INIT;
            drd_cnt_q   <= DRD_INIT;
            bank_q      <= '0;
            bank_q1     <= '0;
            bank_q2     <= '0;
            bank_q3     <= 1'b0;
            bank_q4     <= 1'b0;
            bank_q5     <= 1'b0;
            bank_wr_q   <= '0;
            bank_addr_q <= '0;
            tbu0_en_q   <= 1'b0;
            tbu1_en_q   <= 1'b0;
            tbu0_sel_q  <= 1'b0;
            tbu1_sel_q  <= 1'b0;
            t0s0_q      <= '0;
            t0s1_q      <= '0;
            t1s0_q      <= '0;
            t1s1_q      <= '0;
            disp0_q     <= '0;
            disp1_q     <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            dwr_cnt_q   <= dwr_cnt_d;
            drd_cnt_q   <= drd_cnt_d;
            bank_q      <= bank_d;
            bank_q1     <= bank_q;
            bank_q2     <= bank_q1;
            bank_q3     <= bank_q2[0];
            bank_q4     <= bank_q3;
            bank_q5     <= bank_q4;
            bank_wr_q   <= bank_wr_d;
            bank_addr_q <= bank_addr_d;
            tbu0_en_q   <= tbu0_en_q | (bank_q2 == 2'd2);
            tbu1_en_q   <= tbu1_en_q | (bank_q2 == 2'd3);
            tbu0_sel_q  <= tbu0_sel_d;
            tbu1_sel_q  <= tbu1_sel_d;
            t0s0_q      <= t0s0_d;
            t0s1_q      <= t0s1_d;
            t1s0_q      <= t1s0_d;
            t1s1_q      <= t1s1_d;
            disp0_q     <= disp0_d;
            disp1_q     <= disp1_d;
        end
    end

    assign bank_wr_o      = bank_wr_q;
    assign bank_addr_o    = bank_addr_q;
    assign tbu0_en_o      = tbu0_en_q;
    assign tbu1_en_o      = tbu1_en_q;
    assign tbu0_sel_o     = tbu0_sel_q;
    assign tbu1_sel_o     = tbu1_sel_q;
    assign tbu0_src0_o    = t0s0_q;
    assign tbu0_src1_o    = t0s1_q;
    assign tbu1_src0_o    = t1s0_q;
    assign tbu1_src1_o    = t1s1_q;
    assign disp_addr0_o   = disp0_q;
    assign disp_addr1_o   = disp1_q;
    assign disp_out_sel_o = bank_q5;

endmodule

// File: tb/tb_trellis_bank_sched.sv
// Randomised bench for trellis_bank_sched (ADDR_W = 4) against a run-length/bank-history model.
module tb_trellis_bank_sched;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, enable;
    logic [3:0]    bank_wr;
    logic [4*AW-1:0] bank_addr;
    logic          tbu0_en, tbu1_en, tbu0_sel, tbu1_sel;
    logic [1:0]    tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1;
    logic [AW-1:0] disp_addr0, disp_addr1;
    logic          disp_out_sel;

    int tests = 0;
    int fails = 0;

    trellis_bank_sched #(.ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .bank_wr_o(bank_wr), .bank_addr_o(bank_addr),
        .tbu0_en_o(tbu0_en), .tbu1_en_o(tbu1_en),
        .tbu0_sel_o(tbu0_sel), .tbu1_sel_o(tbu1_sel),
        .tbu0_src0_o(tbu0_src0), .tbu0_src1_o(tbu0_src1),
        .tbu1_src0_o(tbu1_src0), .tbu1_src1_o(tbu1_src1),
        .disp_addr0_o(disp_addr0), .disp_addr1_o(disp_addr1),
        .disp_out_sel_o(disp_out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: run = consecutive enabled edges since counters last re-initialised;
    // bank_at[c] = bank index after edge c; delayed copies read from history.
    int  c = 0;
    int  last_rst = 0;
    int  run = 0;
    int  bank = 0;
    int  bank_at [0:8191];
    bit  model_ok = 0;
    logic [3:0]    e_wr;
    logic [4*AW-1:0] e_addr;
    logic          e_t0en, e_t1en, e_t0sel, e_t1sel, e_dsel;
    logic [1:0]    e_s00, e_s01, e_s10, e_s11;
    logic [AW-1:0] e_d0, e_d1;

    function automatic int qd(input int cyc, input int k);
        if (cyc - k >= last_rst && cyc - k >= 0) return bank_at[cyc - k];
        return 0;
    endfunction

    always @(posedge clk) begin
        int q2p, q3p, wr, rd, rel, dwr, drd;
        c = c + 1;
        if (rst) begin
            e_wr = '0; e_addr = '0; e_t0en = 0; e_t1en = 0; e_t0sel = 0; e_t1sel = 0;
            e_s00 = 0; e_s01 = 0; e_s10 = 0; e_s11 = 0; e_d0 = 0; e_d1 = 0;
            run = 0; bank = 0; last_rst = c; bank_at[c] = 0;
        end else begin
            wr  = run & 15;
            rd  = (15 - run) & 15;
            dwr = (2 - run) & 15;
            drd = (13 + run) & 15;
            q2p = qd(c - 1, 2);
            q3p = qd(c - 1, 3) & 1;
            e_wr = enable ? 4'(1 << bank) : 4'd0;
            for (int k = 0; k < 4; k++) begin
                rel = (k - bank) & 3;
                e_addr[k*AW +: AW] = (rel == 0) ? 4'(wr) : (rel == 2) ? 4'd0 : 4'(rd);
            end
            e_t0en = e_t0en | (q2p == 2);
            e_t1en = e_t1en | (q2p == 3);
            case (q2p)
                0: begin e_s00 = 3; e_s01 = 2; e_t0sel = 0; e_s10 = 2; e_s11 = 1; e_t1sel = 1; end
                1: begin e_s00 = 3; e_s01 = 2; e_t0sel = 1; e_s10 = 0; e_s11 = 3; e_t1sel = 0; end
                2: begin e_s00 = 1; e_s01 = 0; e_t0sel = 0; e_s10 = 0; e_s11 = 3; e_t1sel = 1; end
                default: begin e_s00 = 1; e_s01 = 0; e_t0sel = 1; e_s10 = 2; e_s11 = 1; e_t1sel = 0; end
            endcase
            e_d0 = q3p ? 4'(dwr) : 4'(drd);
            e_d1 = q3p ? 4'(drd) : 4'(dwr);
            if (enable) begin
                if (wr == 15) bank = (bank + 1) & 3;
                run = run + 1;
            end else begin
                run = 0;
            end
            bank_at[c] = bank;
        end
        e_dsel = 1'(qd(c, 5) & 1);
        model_ok = 1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("bank_wr", 32'(bank_wr), 32'(e_wr));
            chk("bank_addr", 32'(bank_addr), 32'(e_addr));
            chk("tbu_en", 32'({tbu0_en, tbu1_en}), 32'({e_t0en, e_t1en}));
            chk("tbu_route", 32'({tbu0_src0, tbu0_src1, tbu0_sel, tbu1_src0, tbu1_src1, tbu1_sel}),
                32'({e_s00, e_s01, e_t0sel, e_s10, e_s11, e_t1sel}));
            chk("disp_addr", 32'({disp_addr0, disp_addr1}), 32'({e_d0, e_d1}));
            chk("disp_out_sel", 32'(disp_out_sel), 32'(e_dsel));
        end
    end

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_bank_wr", 32'(bank_wr), 32'd0);
        chk("rst_tbu0_en", 32'(tbu0_en), 32'd0);
        chk("rst_disp", 32'({disp_addr0, disp_addr1}), 32'd0);
        rst = 1'b0;

        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            case (i)
                1: begin
                    chk("lit_wr1", 32'(bank_wr), 32'h1);
                    chk("lit_addrA1", 32'(bank_addr[0 +: AW]), 32'd0);
                    chk("lit_addrB1", 32'(bank_addr[AW +: AW]), 32'd15);
                    chk("lit_addrC1", 32'(bank_addr[2*AW +: AW]), 32'd0);
                    chk("lit_addrD1", 32'(bank_addr[3*AW +: AW]), 32'd15);
                    chk("lit_disp1", 32'({disp_addr0, disp_addr1}), 32'({4'd13, 4'd2}));
                end
                2: begin
                    chk("lit_addrB2", 32'(bank_addr[AW +: AW]), 32'd14);
                    chk("lit_disp2", 32'({disp_addr0, disp_addr1}), 32'({4'd14, 4'd1}));
                end
                3: chk("lit_disp3", 32'({disp_addr0, disp_addr1}), 32'({4'd15, 4'd0}));
                4: chk("lit_disp4", 32'({disp_addr0, disp_addr1}), 32'({4'd0, 4'd15}));
                17: chk("lit_wr17", 32'(bank_wr), 32'h2);
                18: chk("lit_tbu1_q0", 32'({tbu1_src0, tbu1_src1, tbu1_sel}), 32'({2'd2, 2'd1, 1'b1}));
                19: chk("lit_tbu1_q1", 32'({tbu1_src0, tbu1_src1, tbu1_sel}), 32'({2'd0, 2'd3, 1'b0}));
                20: chk("lit_dsel20", 32'(disp_out_sel), 32'd0);
                21: chk("lit_dsel21", 32'(disp_out_sel), 32'd1);
                33: chk("lit_wr33", 32'(bank_wr), 32'h4);
                34: chk("lit_t0en34", 32'(tbu0_en), 32'd0);
                35: chk("lit_t0en35", 32'(tbu0_en), 32'd1);
                49: chk("lit_wr49", 32'(bank_wr), 32'h8);
                50: chk("lit_t1en50", 32'(tbu1_en), 32'd0);
                51: chk("lit_t1en51", 32'(tbu1_en), 32'd1);
                default: ;
            endcase
        end

        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_pulse_wr", 32'(bank_wr), 32'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("lit_resume_wr", 32'(bank_wr), 32'h8);
        chk("lit_resume_addr", 32'(bank_addr), 32'({4'd0, 4'd15, 4'd0, 4'd15}));
        chk("lit_resume_disp", 32'({disp_addr0, disp_addr1}), 32'({4'd2, 4'd13}));

        for (int i = 0; i < 1400; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 29) != 0);
            @(negedge clk);
        end

        rst = 1'b0;
        enable = 1'b1;
        repeat (80) @(negedge clk);
        chk("lit_sticky", 32'({tbu0_en, tbu1_en}), 32'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("lit_mrst_wr", 32'(bank_wr), 32'd0);
        chk("lit_mrst_addr", 32'(bank_addr), 32'd0);
        chk("lit_mrst_tbu", 32'({tbu0_en, tbu1_en, tbu0_sel, tbu1_sel, tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1}), 32'd0);
        chk("lit_mrst_disp", 32'({disp_addr0, disp_addr1, disp_out_sel}), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
